// File: rtl/float_calc_ctrl.sv
// Request/response sequencer for float_calc: holds operands for a
// settle window, then captures the selected result and its flags.
module float_calc_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [1:0]  req_op,
  output logic [31:0] calc_a,
  output logic [31:0] calc_b,
  input  logic [31:0] calc_add,
  input  logic [31:0] calc_sub,
  input  logic [31:0] calc_mul,
  input  logic [31:0] calc_div,
  input  logic [3:0]  calc_overflow,
  input  logic        calc_err,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_ovf,
  output logic        rsp_err,
  output logic        busy,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_reg;
  logic [31:0]      sel;

  always_comb begin
    sel = calc_add;
    unique case (op_reg)
      2'd0: sel = calc_add;
      2'd1: sel = calc_sub;
      2'd2: sel = calc_mul;
      2'd3: sel = calc_div;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_reg    <= '0;
      calc_a    <= '0;
      calc_b    <= '0;
      rsp_data  <= '0;
      rsp_ovf   <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_valid <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            calc_a    <= req_a;
            calc_b    <= req_b;
            op_reg    <= req_op;
            cnt       <= CNT_W'(SETTLE_CYCLES);
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            rsp_data  <= sel;
            rsp_ovf   <= calc_overflow[op_reg];
            rsp_err   <= calc_err & (op_reg == 2'd3);
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
            if (op_count != 16'hFFFF)
              op_count <= op_count + 16'd1;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/float_calc_ctrl.md
Name: float_calc_ctrl

Overview:
- Front-end sequencer for the float_calc arithmetic block.
- Accepts one operation request (A, B, opcode) over a valid/ready handshake and drives float_calc's A/B inputs with stable operands for a programmable settle window.
- Captures the selected result plus its overflow and error flags, then presents them on a valid/ready response port.
- Sits between the operand source (keypad/bus logic) and float_calc.

Parameters:
- SETTLE_CYCLES, 4, cycles operands are held before result capture; legal range 1..15.
- CNT_W, 4, width of settle counter; must hold SETTLE_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept request.
- req_a  in  32  IEEE-754 single operand A.
- req_b  in  32  IEEE-754 single operand B.
- req_op  in  2  0=add, 1=sub, 2=mul, 3=div.
- calc_a  out  32  operand A to float_calc.
- calc_b  out  32  operand B to float_calc.
- calc_add  in  32  float_calc add result.
- calc_sub  in  32  float_calc sub result.
- calc_mul  in  32  float_calc mul result.
- calc_div  in  32  float_calc div result.
- calc_overflow  in  4  float_calc overflow flags, bit0=add, bit1=sub, bit2=mul, bit3=div.
- calc_err  in  1  float_calc error (divide by zero / invalid).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  32  selected result.
- rsp_ovf  out  1  calc_overflow[op] captured.
- rsp_err  out  1  calc_err captured, qualified by op==3.
- busy  out  1  high in SETTLE or RESP.
- op_count  out  16  completed responses, saturates at 0xFFFF.

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE.
  - calc_a, calc_b, rsp_data, rsp_ovf, rsp_err, rsp_valid, busy, op_count all 0.
  - req_ready=1 in the cycle after reset.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1: latch req_a→calc_a, req_b→calc_b, req_op→op_reg; load cnt=SETTLE_CYCLES; go to SETTLE.
- SETTLE:
  - req_ready=0; calc_a/calc_b held constant.
  - cnt decrements each edge.
  - On the edge where cnt==1, capture into rsp_* and go to RESP:
    - rsp_data = mux(op_reg: add/sub/mul/div).
    - rsp_ovf = calc_overflow[op_reg].
    - rsp_err = calc_err & (op_reg==3).
- RESP:
  - rsp_valid=1; rsp_data/rsp_ovf/rsp_err held stable.
  - On an edge with rsp_ready=1: rsp_valid→0, op_count increments (holds at 0xFFFF), go to IDLE.
- Latency: request accepted at edge E0 → rsp_valid high after edge E0+SETTLE_CYCLES. With rsp_ready tied high, there is one idle cycle between responses; requests are accepted no more often than once per SETTLE_CYCLES+2 cycles.
- req_valid is ignored outside IDLE. The source must hold req_* until req_ready; it is not lost.
- calc_a/calc_b keep the last operands after the response; they change only on acceptance or reset.
- busy = (state != IDLE).
- Reset mid-SETTLE or mid-RESP: operation abandoned, no response, op_count cleared, rsp_valid low on the next cycle.
- rsp_ready high outside RESP: no effect.
- Unknown opcode is impossible (2-bit, fully decoded).

Test Plan:
- Reset: hold rst 3 cycles → all outputs 0, req_ready=1, busy=0.
- Add: A=0x3F800000, B=0x40000000, op=0, rsp_ready=1 → rsp_valid after 4 edges, rsp_data=0x40400000, rsp_ovf=0, rsp_err=0, op_count=1.
- Mul overflow: A=0x7F7FFFFF, B=0x40000000, op=2 → rsp_data=float_calc mul output (0x7F800000), rsp_ovf=1.
- Div by zero: A=0x3F800000, B=0x00000000, op=3 → rsp_err=1. Same operands with op=0 → rsp_err=0, rsp_data=0x3F800000.
- Backpressure: rsp_ready low 10 cycles, req_valid held high with new operands → rsp_data stable, req_ready=0, calc_a unchanged. Raise rsp_ready → next request accepted one cycle later.
- Reset mid-op: rst pulse on SETTLE cycle 2 → no rsp_valid, op_count=0, next request completes normally.
